uart16550_sin_frontend: RTL and testbench
=========================================

# uart16550_sin_frontend

Receive-line front end placed between the `sin_i` pin and the `uart16550_rx` block. It synchronises the asynchronous serial input into `clk_i`, rejects short glitches, and presents a clean `sin_o` to the receiver. On request it also runs an autobaud measurement on the first start bit and returns a 16-bit divisor in the same 16x-oversampling format as DLL/DLM, so software can program the divisor latch.

## Interface
- `SYNC_STAGES`, 2: number of synchroniser flops, 2..4.
- `FILTER_LEN`, 3: consecutive cycles a new level must persist before `sin_o` follows, 1..15.
- `CNT_W`, 20: width of the autobaud cycle counter, 8..24.
- `DL_RESET_VALUE`, 16'ha3: reset value of `dl_o`.

Ports:
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `sin_i` in 1: asynchronous serial input; idle is 1.
- `sin_o` out 1: synchronised, filtered serial line to the receiver.
- `ab_start_i` in 1: start an autobaud measurement; sampled only in IDLE.
- `ab_abort_i` in 1: abort an autobaud measurement; accepted in any state.
- `ab_busy_o` out 1: high in every state except IDLE.
- `ab_done_o` out 1: one-cycle pulse when a measurement completes, whether valid or error.
- `ab_error_o` out 1: status of the last completed measurement.
- `dl_o` out 16: measured divisor; holds its value between completions.

## Operation
- **Synchroniser**
  - Chain of `SYNC_STAGES` flops; every flop resets to 1.
  - `s_sync` is the last flop.
- **Filter**
  - 4-bit counter `fcnt`, reset value 0.
  - When `s_sync == sin_o`: `fcnt` returns to 0.
  - When `s_sync != sin_o` and `fcnt == FILTER_LEN-1`: `sin_o` takes `s_sync` and `fcnt` returns to 0.
  - Otherwise `fcnt` increments.
  - Result: a level change on `s_sync` shorter than `FILTER_LEN` cycles never reaches `sin_o`.
- **Autobaud FSM states:** IDLE, WAIT_MARK, WAIT_FALL, MEASURE.
  - IDLE: when `ab_start_i` is high, go to WAIT_MARK.
  - WAIT_MARK: when `sin_o == 1`, go to WAIT_FALL. This keeps a line that is already low from being measured.
  - WAIT_FALL: on a falling edge of `sin_o` (registered `sin_o` was 1, `sin_o` is now 0), load `cnt = 1` and go to MEASURE.
  - MEASURE, while `sin_o == 0`: `cnt` increments and saturates at `2^CNT_W-1`.
  - MEASURE, when `sin_o == 1`:
    - compute `dl = (cnt + 8) >> 4`, which rounds `cnt/16` to nearest, at width `CNT_W-3`;
    - `error = (cnt saturated) | (dl == 0) | (dl > 16'hFFFF)`;
    - if there is no error, load `dl_o <= dl[15:0]`; on error `dl_o` keeps its old value;
    - set `ab_error_o <= error`, pulse `ab_done_o`, go to IDLE.
  - `ab_abort_i` in any non-IDLE state: go to IDLE the next cycle. No `ab_done_o` pulse; `dl_o` and `ab_error_o` are unchanged.
  - `ab_abort_i` has priority over every other transition.
- **Filter timing during measurement:** the measured low period is that of `sin_o`. The filter delays both edges equally, so the measured width equals the input low width.
- **Measurement pattern:** software sends a character with bit0 = 1, such as 0x55 or 'U'. Only the start bit is measured.
- **Reset mid-operation:**
  - FSM goes to IDLE; `cnt` clears to 0.
  - `dl_o` returns to `DL_RESET_VALUE`; `ab_error_o` to 0; `sin_o` to 1.

## Timing
- **Reset values:** `sin_o` = 1, `ab_busy_o` = 0, `ab_done_o` = 0, `ab_error_o` = 0, `dl_o` = `DL_RESET_VALUE`.
- **Pin to `sin_o` latency:** a clean edge on `sin_i`, setup-met before rising edge N, appears on `sin_o` after rising edge `N + SYNC_STAGES + FILTER_LEN - 1`. With defaults this is 4 cycles.
- **`ab_busy_o`:** rises the cycle after `ab_start_i` is sampled in IDLE; falls in the same cycle `ab_done_o` is high.
- **Rising edge of `sin_o` at cycle R (end of the low period):**
  - `ab_done_o`, `ab_error_o` and `dl_o` all update at R+1;
  - `ab_done_o` is high for exactly that one cycle.
- **Measured count:** equals the number of cycles `sin_o` was 0, exactly; no ±1 slack.
- **`ab_start_i` and completion in the same cycle:** `ab_start_i` is ignored, because it is sampled only in IDLE.
- **Back-to-back measurements:** allowed. A new `ab_start_i` is sampled in the first IDLE cycle after the completion.

## Test plan
- **Reset values:** assert `rst_i` for 2 cycles with `sin_i = 0` -> `sin_o = 1`, `dl_o = 16'h00a3`, `ab_busy_o = 0`, `ab_done_o = 0`, `ab_error_o = 0`. Then `sin_o` falls exactly 4 cycles after release.
- **Glitch rejection (defaults):** a low pulse of 2 cycles on `sin_i` -> `sin_o` stays 1. A low pulse of 3 cycles -> `sin_o` is low for exactly 3 cycles, 4 cycles delayed.
- **Autobaud 9600 Bd at 25 MHz:** `ab_start_i`, then send 0x55 with 2604-cycle bits -> a single `ab_done_o` pulse, `dl_o = 16'h00a3`, `ab_error_o = 0`. A start bit of 1000 cycles -> `dl_o = 63`, `ab_error_o = 0`.
- **Underflow:** a start bit of 7 cycles with `FILTER_LEN = 1` -> `ab_error_o = 1`, `dl_o` unchanged.
- **Line low at start:** `ab_start_i` while `sin_o = 0` for 500 cycles, then a normal 0x55 frame -> the first low is ignored and `dl_o` reflects the 0x55 start bit only.
- **Abort and overflow:**
  - `ab_abort_i` in MEASURE -> no `ab_done_o` pulse, `ab_busy_o` = 0 next cycle, `dl_o` unchanged.
  - `sin_i` held low for more than `2^CNT_W` cycles -> `cnt` saturates; at the rising edge `ab_done_o` pulses with `ab_error_o = 1`.

Source files
------------

// File: rtl/uart16550_sin_frontend.sv
// uart16550_sin_frontend
//
// Receive-line front end that sits between the serial input pin and the
// uart16550_rx block. It brings the asynchronous pin into the clk_i domain,
// removes short glitches, and hands a clean line to the receiver. On request
// it also times the first start bit it sees. It then returns a divisor in the
// same 16x-oversampling format as DLL/DLM, so software can load it directly.
//
// Ports:
//   clk_i       in   1  single clock, rising edge
//   rst_i       in   1  synchronous active-high reset
//   sin_i       in   1  asynchronous serial input, idle high
//   sin_o       out  1  synchronised, glitch-filtered serial line
//   ab_start_i  in   1  start an autobaud measurement (honoured only when idle)
//   ab_abort_i  in   1  abandon a measurement in progress
//   ab_busy_o   out  1  a measurement is armed or running
//   ab_done_o   out  1  one-cycle pulse when a measurement completes
//   ab_error_o  out  1  status of the last completed measurement
//   dl_o        out 16  last valid measured divisor
module uart16550_sin_frontend #(
  parameter int          SYNC_STAGES    = 2,
  parameter int          FILTER_LEN     = 3,
  parameter int          CNT_W          = 20,
  parameter logic [15:0] DL_RESET_VALUE = 16'ha3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sin_i,
  output logic        sin_o,
  input  logic        ab_start_i,
  input  logic        ab_abort_i,
  output logic        ab_busy_o,
  output logic        ab_done_o,
  output logic        ab_error_o,
  output logic [15:0] dl_o
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_MARK = 2'd1;
  localparam logic [1:0] ST_WAIT_FALL = 2'd2;
  localparam logic [1:0] ST_MEASURE   = 2'd3;

  localparam logic [3:0]       FILT_LAST = 4'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_sync;
  logic [3:0]             fcnt;
  logic                   sin_prev;
  logic [1:0]             state;
  logic [CNT_W-1:0]       cnt;
  logic [31:0]            sum_ext;
  logic [31:0]            dl_ext;
  logic                   cnt_sat;
  logic                   meas_err;

  // Synchroniser chain. Flops reset to the idle (mark) level so that reset
  // never looks like a start bit to the receiver.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sin_i};
    end
  end

  assign s_sync = sync_q[SYNC_STAGES-1];

  // The output follows a new level only after that level has persisted for
  // FILTER_LEN consecutive cycles. Both edges are delayed by the same amount,
  // so the width of any accepted pulse is preserved.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fcnt  <= 4'd0;
      sin_o <= 1'b1;
    end else if (s_sync == sin_o) begin
      fcnt <= 4'd0;
    end else if (fcnt == FILT_LAST) begin
      sin_o <= s_sync;
      fcnt  <= 4'd0;
    end else begin
      fcnt <= fcnt + 4'd1;
    end
  end

  // Delayed copy of the filtered line for falling-edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sin_prev <= 1'b1;
    end else begin
      sin_prev <= sin_o;
    end
  end

  // Divisor is the low time divided by 16, rounded to nearest. The sum is
  // carried at 32 bits, so the same expression works for every CNT_W. The
  // upper bits are kept so that an oversize divisor can be detected.
  assign sum_ext  = 32'(cnt) + 32'd8;
  assign dl_ext   = sum_ext >> 4;
  assign cnt_sat  = (cnt == CNT_MAX);
  assign meas_err = cnt_sat || (dl_ext == 32'd0) || (dl_ext > 32'h0000_FFFF);

  // Autobaud sequencer. WAIT_MARK keeps a line that is already low when the
  // measurement is armed from being timed. Only a genuine 1->0 transition
  // opens the window. The first low cycle is counted when the edge is seen,
  // so the final count equals the low width exactly. Abort overrides all.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      dl_o       <= DL_RESET_VALUE;
      ab_error_o <= 1'b0;
      ab_done_o  <= 1'b0;
    end else begin
      ab_done_o <= 1'b0;
      if (ab_abort_i && (state != ST_IDLE)) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (ab_start_i) state <= ST_WAIT_MARK;
          end
          ST_WAIT_MARK: begin
            if (sin_o) state <= ST_WAIT_FALL;
          end
          ST_WAIT_FALL: begin
            if (sin_prev && !sin_o) begin
              cnt   <= CNT_ONE;
              state <= ST_MEASURE;
            end
          end
          ST_MEASURE: begin
            if (!sin_o) begin
              if (!cnt_sat) cnt <= cnt + CNT_ONE;
            end else begin
              if (!meas_err) dl_o <= dl_ext[15:0];
              ab_error_o <= meas_err;
              ab_done_o  <= 1'b1;
              state      <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign ab_busy_o = (state != ST_IDLE);

endmodule

// File: tb/tb_uart16550_sin_frontend.sv
// Testbench for uart16550_sin_frontend.
// Two instances are used: dut_a with default parameters, and dut_b with
// FILTER_LEN=1 and CNT_W=12. dut_b makes underflow and counter saturation
// reachable in a short run. Expected divisors come from the rounding rule
// applied to the known low width of the driven start bit.
module tb_uart16550_sin_frontend;

  logic        clk = 1'b0;
  logic        rst;
  logic        sin_a, sin_b;
  logic        start_a, start_b;
  logic        abort_a, abort_b;
  logic        sin_o_a, sin_o_b;
  logic        busy_a, busy_b;
  logic        done_a, done_b;
  logic        err_a, err_b;
  logic [15:0] dl_a, dl_b;

  logic        m_sin_o, m_busy, m_done, m_err;
  logic [15:0] m_dl;

  bit          sel;
  int          vectors = 0;
  int          miscompares = 0;
  int          done_count;
  int          done_step;
  int          early;
  int          w;
  logic [15:0] got_dl;
  logic        got_err;
  logic [15:0] exp_dl_a, exp_dl_b;
  logic        exp_err_a, exp_err_b;

  always #5 clk = ~clk;

  uart16550_sin_frontend dut_a (
    .clk_i(clk), .rst_i(rst), .sin_i(sin_a), .sin_o(sin_o_a),
    .ab_start_i(start_a), .ab_abort_i(abort_a), .ab_busy_o(busy_a),
    .ab_done_o(done_a), .ab_error_o(err_a), .dl_o(dl_a)
  );

  uart16550_sin_frontend #(.FILTER_LEN(1), .CNT_W(12)) dut_b (
    .clk_i(clk), .rst_i(rst), .sin_i(sin_b), .sin_o(sin_o_b),
    .ab_start_i(start_b), .ab_abort_i(abort_b), .ab_busy_o(busy_b),
    .ab_done_o(done_b), .ab_error_o(err_b), .dl_o(dl_b)
  );

  assign m_sin_o = sel ? sin_o_b : sin_o_a;
  assign m_busy  = sel ? busy_b  : busy_a;
  assign m_done  = sel ? done_b  : done_a;
  assign m_err   = sel ? err_b   : err_a;
  assign m_dl    = sel ? dl_b    : dl_a;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic driveSin(input logic v);
    if (sel) sin_b = v; else sin_a = v;
  endtask

  task automatic driveStart(input logic v);
    if (sel) start_b = v; else start_a = v;
  endtask

  task automatic driveAbort(input logic v);
    if (sel) abort_b = v; else abort_a = v;
  endtask

  task automatic pulseStart();
    driveStart(1'b1);
    step();
    driveStart(1'b0);
    checkOutput("busy_after_start", 32'(m_busy), 32'd1);
  endtask

  // Rounded divisor and error status, from the low width alone.
  function automatic int modelDl(input int width);
    return (width + 8) / 16;
  endfunction

  function automatic logic modelErr(input int width, input int cntw);
    int d;
    d = (width + 8) / 16;
    return (width >= (1 << cntw) - 1) || (d == 0) || (d > 65535);
  endfunction

  // Drives nbits LSB-first bits of bit_len cycles each, then idles high for
  // tail cycles. Records completion pulses, optionally aborting at one step.
  task automatic applyStimulus(input logic [9:0] bits, input int nbits, input int bit_len,
                               input int tail, input int abort_step);
    int total;
    done_count = 0;
    done_step  = -1;
    total = nbits * bit_len + tail;
    for (int t = 0; t < total; t++) begin
      if (t < nbits * bit_len) driveSin(bits[t / bit_len]);
      else driveSin(1'b1);
      if (t == abort_step) driveAbort(1'b1);
      step();
      driveAbort(1'b0);
      if (t == abort_step) checkOutput("abort_busy", 32'(m_busy), 32'd0);
      if (m_done) begin
        done_count++;
        if (done_step < 0) begin
          done_step = t + 1;
          got_dl    = m_dl;
          got_err   = m_err;
          checkOutput("busy_at_done", 32'(m_busy), 32'd0);
        end
      end
    end
  endtask

  task automatic runMeasure(input string tag, input bit do_start, input logic [9:0] bits,
                            input int nbits, input int bit_len);
    int   lat;
    int   cntw;
    logic e;
    logic [15:0] edl;
    lat  = sel ? 3 : 5;
    cntw = sel ? 12 : 20;
    if (do_start) pulseStart();
    applyStimulus(bits, nbits, bit_len, 40, -1);
    e = modelErr(bit_len, cntw);
    if (sel) begin
      if (!e) exp_dl_b = 16'(modelDl(bit_len));
      exp_err_b = e;
      edl = exp_dl_b;
    end else begin
      if (!e) exp_dl_a = 16'(modelDl(bit_len));
      exp_err_a = e;
      edl = exp_dl_a;
    end
    checkOutput({tag, "_done_count"}, 32'(done_count), 32'd1);
    checkOutput({tag, "_done_time"}, 32'(done_step), 32'(lat + bit_len + 1));
    checkOutput({tag, "_dl"}, 32'(got_dl), 32'(edl));
    checkOutput({tag, "_err"}, 32'(got_err), 32'(e));
    checkOutput({tag, "_idle"}, 32'(m_busy), 32'd0);
  endtask

  // Low pulse of len cycles on dut_a: shorter than the filter length it must
  // vanish; otherwise it reappears with the same width, 5 cycles later.
  task automatic runGlitch(input int len);
    int lows;
    int first;
    sel   = 1'b0;
    lows  = 0;
    first = -1;
    for (int t = 0; t < 20; t++) begin
      driveSin((t < len) ? 1'b0 : 1'b1);
      step();
      if (!m_sin_o) begin
        lows++;
        if (first < 0) first = t + 1;
      end
    end
    checkOutput($sformatf("glitch%0d_width", len), 32'(lows), (len < 3) ? 32'd0 : 32'(len));
    checkOutput($sformatf("glitch%0d_delay", len), 32'(first), (len < 3) ? 32'hFFFF_FFFF : 32'd5);
  endtask

  initial begin
    sel = 1'b0;
    rst = 1'b1;
    sin_a = 1'b0; sin_b = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    abort_a = 1'b0; abort_b = 1'b0;
    exp_dl_a = 16'h00a3; exp_dl_b = 16'h00a3;
    exp_err_a = 1'b0; exp_err_b = 1'b0;

    // Reset values with the line held low.
    step();
    step();
    checkOutput("rst_sin_o", 32'(sin_o_a), 32'd1);
    checkOutput("rst_dl_a", 32'(dl_a), 32'h00a3);
    checkOutput("rst_dl_b", 32'(dl_b), 32'h00a3);
    checkOutput("rst_busy", 32'(busy_a), 32'd0);
    checkOutput("rst_done", 32'(done_a), 32'd0);
    checkOutput("rst_err", 32'(err_a), 32'd0);
    rst = 1'b0;
    repeat (4) step();
    checkOutput("release_sin_o_early", 32'(sin_o_a), 32'd1);
    step();
    checkOutput("release_sin_o_fall", 32'(sin_o_a), 32'd0);
    sin_a = 1'b1; sin_b = 1'b1;
    repeat (20) step();

    // Glitch filter, fixed then random pulse widths.
    runGlitch(2);
    runGlitch(3);
    for (int i = 0; i < 6; i++) runGlitch(int'($urandom_range(1, 6)));

    // 9600 Bd at 25 MHz, then a 1000-cycle start bit.
    sel = 1'b0;
    runMeasure("frame_9600", 1'b1, 10'h2AA, 10, 2604);
    runMeasure("start_1000", 1'b1, 10'h000, 1, 1000);

    // Line already low when the measurement is armed.
    driveSin(1'b0);
    repeat (20) step();
    pulseStart();
    early = 0;
    for (int t = 0; t < 480; t++) begin
      step();
      if (m_done) early++;
    end
    checkOutput("lowstart_no_done", 32'(early), 32'd0);
    checkOutput("lowstart_busy", 32'(m_busy), 32'd1);
    driveSin(1'b1);
    repeat (20) step();
    runMeasure("lowstart", 1'b0, 10'h2AA, 10, 800);

    // Abort in the middle of the measured low period.
    pulseStart();
    applyStimulus(10'h000, 1, 300, 40, 150);
    checkOutput("abort_no_done", 32'(done_count), 32'd0);
    checkOutput("abort_dl", 32'(m_dl), 32'(exp_dl_a));
    checkOutput("abort_err", 32'(m_err), 32'(exp_err_a));

    // Random start-bit widths on the default instance.
    for (int i = 0; i < 4; i++) begin
      w = int'($urandom_range(3, 2000));
      runMeasure($sformatf("rand_a_%0d", w), 1'b1, 10'h000, 1, w);
    end

    // Short filter, narrow counter: valid, underflow, saturation, edge.
    sel = 1'b1;
    repeat (10) step();
    runMeasure("b_500", 1'b1, 10'h000, 1, 500);
    runMeasure("underflow", 1'b1, 10'h000, 1, 7);
    runMeasure("saturate", 1'b1, 10'h000, 1, 4200);
    runMeasure("b_4094", 1'b1, 10'h000, 1, 4094);
    for (int i = 0; i < 4; i++) begin
      w = int'($urandom_range(1, 4200));
      runMeasure($sformatf("rand_b_%0d", w), 1'b1, 10'h000, 1, w);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
